// File: rtl/k12a_spi_multi_if.sv
// rtl/k12a_spi_multi_if.sv - host-side and SPI-side signal bundle for k12a_spi_multi
interface k12a_spi_multi_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int DIV_WIDTH    = 8
);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                    start;
    logic [CW-1:0]           chan_sel;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic [DIV_WIDTH-1:0]    divisor;
    logic                    cpol;
    logic                    cpha;
    logic                    msb_first;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [DATA_WIDTH-1:0]   rx_data;
    logic [NUM_CHANNELS-1:0] sck;
    logic [NUM_CHANNELS-1:0] mosi;
    logic [NUM_CHANNELS-1:0] cs_n;
    logic [NUM_CHANNELS-1:0] miso;

    modport master (
        output start, chan_sel, tx_data, divisor, cpol, cpha, msb_first, miso,
        input  busy, done, err, rx_data, sck, mosi, cs_n
    );

    modport slave (
        input  start, chan_sel, tx_data, divisor, cpol, cpha, msb_first, miso,
        output busy, done, err, rx_data, sck, mosi, cs_n
    );
endinterface

// File: rtl/k12a_spi_multi.sv
// rtl/k12a_spi_multi.sv - multi-channel SPI master: one shared FSM, per-channel sck/mosi/cs_n
module k12a_spi_multi #(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int DIV_WIDTH    = 8
) (
    input  logic            cpu_clock,
    input  logic            reset,
    k12a_spi_multi_if.slave bus
);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int HW = $clog2(2 * DATA_WIDTH);
    localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_sel;
    logic [DIV_WIDTH-1:0]    r_div;
    logic [DIV_WIDTH-1:0]    r_cnt;
    logic [HW-1:0]           r_half;
    logic                    r_cpol;
    logic                    r_cpha;
    logic                    r_msb;
    logic [DATA_WIDTH-1:0]   r_tx_sh;
    logic [DATA_WIDTH-1:0]   r_rx_sh;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [NUM_CHANNELS-1:0] r_sck;
    logic [NUM_CHANNELS-1:0] r_mosi;
    logic [NUM_CHANNELS-1:0] r_cs_n;

    function automatic logic [DATA_WIDTH-1:0] f_rev(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) r[i] = d[DATA_WIDTH-1-i];
        return r;
    endfunction

    // Words are always shifted MSB-end first; LSB-first mode just bit-reverses on load and on completion.
    logic [DATA_WIDTH-1:0]   w_tx_ord;
    logic [NUM_CHANNELS-1:0] w_start_mask;
    logic [NUM_CHANNELS-1:0] w_sel_mask;
    logic                    w_half_end;
    logic [HW-1:0]           w_edge_idx;
    logic                    w_sample;
    logic                    w_shift;
    logic                    w_miso;

    assign w_tx_ord     = bus.msb_first ? bus.tx_data : f_rev(bus.tx_data);
    assign w_start_mask = NUM_CHANNELS'(1) << bus.chan_sel;
    assign w_sel_mask   = NUM_CHANNELS'(1) << r_sel;
    assign w_half_end   = (r_cnt == r_div);
    assign w_miso       = |(bus.miso & w_sel_mask);

    // sck edge k happens on entry to XFER half k; even k are leading edges.
    // The first bit is already on mosi, so the first shift edge of each mode is skipped.
    assign w_edge_idx = (r_state == LEAD) ? '0 : r_half + HW'(1);
    assign w_sample   = (w_edge_idx[0] == r_cpha);
    assign w_shift    = !w_sample && !(r_cpha && w_edge_idx == '0)
                        && !(!r_cpha && w_edge_idx == LAST_HALF);

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_half    <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_msb     <= 1'b0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_sck     <= '0;
            r_mosi    <= '0;
            r_cs_n    <= '1;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (32'(bus.chan_sel) < NUM_CHANNELS) begin
                            r_state <= LEAD;
                            r_busy  <= 1'b1;
                            r_sel   <= bus.chan_sel;
                            r_div   <= bus.divisor;
                            r_cpol  <= bus.cpol;
                            r_cpha  <= bus.cpha;
                            r_msb   <= bus.msb_first;
                            r_tx_sh <= w_tx_ord << 1;
                            r_rx_sh <= '0;
                            r_cnt   <= '0;
                            r_half  <= '0;
                            r_sck   <= {NUM_CHANNELS{bus.cpol}};
                            r_cs_n  <= ~w_start_mask;
                            r_mosi  <= w_start_mask & {NUM_CHANNELS{w_tx_ord[DATA_WIDTH-1]}};
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                LEAD, XFER, TRAIL: begin
                    if (!w_half_end) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (r_state == TRAIL) begin
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_rx_data <= r_msb ? r_rx_sh : f_rev(r_rx_sh);
                            r_cs_n    <= '1;
                            r_mosi    <= '0;
                        end else if (r_state == XFER && r_half == LAST_HALF) begin
                            r_state <= TRAIL;
                        end else begin
                            r_state <= XFER;
                            r_half  <= w_edge_idx;
                            r_sck   <= r_sck ^ w_sel_mask;
                            if (w_sample) r_rx_sh <= {r_rx_sh[DATA_WIDTH-2:0], w_miso};
                            if (w_shift) begin
                                r_mosi  <= w_sel_mask & {NUM_CHANNELS{r_tx_sh[DATA_WIDTH-1]}};
                                r_tx_sh <= r_tx_sh << 1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.rx_data = r_rx_data;
    assign bus.sck     = r_sck;
    assign bus.mosi    = r_mosi;
    assign bus.cs_n    = r_cs_n;
endmodule

// File: doc/k12a_spi_multi.md
K12A_SPI_MULTI -- requirements
Module: k12a_spi_multi

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2: number of SPI ports (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per transfer (4..32).
REQ-003 SHALL have parameter DIV_WIDTH, default 8: width of the clock divisor.
REQ-004 SHALL have port cpu_clock, in, 1: the single clock; all logic rising-edge.
REQ-005 SHALL have port reset, in, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, in, 1: transfer request, sampled on a cpu_clock edge.
REQ-007 SHALL have port chan_sel, in, CW = max(1, clog2(NUM_CHANNELS)): target channel.
REQ-008 SHALL have port tx_data, in, DATA_WIDTH: word to shift out.
REQ-009 SHALL have port divisor, in, DIV_WIDTH: SCK half-period = divisor+1 cycles.
REQ-010 SHALL have ports cpol, cpha, msb_first, each in, 1: mode and bit order.
REQ-011 SHALL have port busy, out, 1: transfer in progress.
REQ-012 SHALL have port done, out, 1: one-cycle completion pulse.
REQ-013 SHALL have port err, out, 1: one-cycle pulse on a rejected start.
REQ-014 SHALL have port rx_data, out, DATA_WIDTH: last received word.
REQ-015 SHALL have ports sck, mosi and cs_n, each out, NUM_CHANNELS: per-channel SPI outputs.
REQ-016 SHALL have port miso, in, NUM_CHANNELS: per-channel SPI input.

Function
REQ-017 SHALL implement states IDLE, LEAD, XFER and TRAIL.
REQ-018 SHALL, in IDLE with start=1 and chan_sel<NUM_CHANNELS, capture all inputs and enter LEAD; busy=1 from the next cycle.
REQ-019 SHALL ignore start while busy=1, with no err and no effect on the transfer.
REQ-020 SHALL, on start in IDLE with chan_sel>=NUM_CHANNELS, pulse err for one cycle and stay IDLE.
REQ-021 SHALL keep each state duration counted in half-periods of divisor+1 cycles: LEAD 1, XFER 2*DATA_WIDTH, TRAIL 1.
REQ-022 SHALL hold busy for exactly (divisor+1)*(2*DATA_WIDTH+2) cycles per accepted transfer.
REQ-023 SHALL drive cs_n[sel]=0 during LEAD, XFER and TRAIL; every other cs_n SHALL be 1.
REQ-024 SHALL hold every sck at captured cpol outside XFER and toggle sck[sel] at each XFER half-period boundary (DATA_WIDTH full pulses).
REQ-025 SHALL, for cpha=0, present the first bit on mosi[sel] at LEAD entry, sample miso on leading edges and shift on trailing edges.
REQ-026 SHALL, for cpha=1, shift on leading edges and sample on trailing edges.
REQ-027 SHALL send bit DATA_WIDTH-1 first when msb_first=1 and bit 0 first otherwise; received bits SHALL be assembled in the same order.
REQ-028 SHALL drive mosi of unselected channels, and all mosi in IDLE, to 0.
REQ-029 SHALL, in the first cycle after busy falls, pulse done=1 and update rx_data in the same cycle; rx_data SHALL hold until the next done.
REQ-030 SHALL accept a start asserted in the done cycle (back-to-back).
REQ-031 SHALL use divisor=0 as valid (sck toggles every cycle); divisor=all-ones SHALL give 2^DIV_WIDTH cycles per half-period, with no counter wrap error.
REQ-032 SHALL use captured inputs only; changes on cpol, cpha, divisor, tx_data or chan_sel during busy SHALL have no effect.

Reset
REQ-033 SHALL, while reset=1, immediately (without waiting for a clock) force state=IDLE, busy=0, done=0, err=0, rx_data=0, all sck=0, all mosi=0, all cs_n=1.
REQ-034 SHALL, on reset mid-transfer, abort the transfer, with no done pulse and rx_data=0.
REQ-035 SHALL not accept a start until the first cpu_clock edge after reset deasserts.

Verification
REQ-036 SHALL test: N=2, W=8, divisor=0, mode 0, MSB-first, tx=0xA5, miso[0] looped to mosi[0] -> busy 18 cycles, 8 sck[0] pulses, done then rx=0xA5, cs_n[1] stays 1.
REQ-037 SHALL test: mode 3 (cpol=1, cpha=1), divisor=2, tx=0x3C, miso[1] tied 1, chan 1 -> busy 54 cycles, sck[1] idles 1, rx=0xFF.
REQ-038 SHALL test: LSB-first, tx=0x01, loopback -> first mosi bit 1, rx=0x01.
REQ-039 SHALL test: start pulsed again mid-transfer with tx=0xFF -> ignored; rx equals the original word; exactly one done.
REQ-040 SHALL test: N=3, start with chan_sel=3 -> err pulses one cycle, busy stays 0, all cs_n=1.
REQ-041 SHALL test: reset asserted during XFER -> outputs at reset values asynchronously, no done; a new transfer after release completes normally.
